oled_display_arbiter: RTL and testbench
=======================================

Name: oled_display_arbiter

Overview:
- Shares the single 96x64 OLED (Oled_Display) among NUM_REQ screen producers: maze, wire-cut, colour game.
- Registered one-hot grant drives a combinational pixel mux into Oled_Display pixel_data.
- Ownership changes only on frame boundaries, so frames never tear.
- Round-robin among requesters, with a minimum hold time, an owner lock, and blank frames between owners.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- MIN_HOLD_FRAMES, 4, completed frames an owner keeps the screen before it can be preempted (1..255).
- BLANK_FRAMES, 2, BLANK_COLOUR frames inserted on every owner change (1..255).
- IDLE_COLOUR, 16'h0000, pixel value when no owner.
- BLANK_COLOUR, 16'h0000, pixel value during a transition.

Ports:
- clk, input, 1, OLED pixel clock (6.25 MHz, same clock as Oled_Display).
- reset_n, input, 1, asynchronous active-low reset.
- frame_begin, input, 1, Oled_Display frame_begin.
- req, input, NUM_REQ, per-requester screen request, level.
- lock, input, 1, current owner blocks preemption while high.
- pix_in, input, 16*NUM_REQ, requester i pixel at bits [16i+15:16i], RGB565.
- pixel_data, output, 16, to Oled_Display pixel_data.
- grant, output, NUM_REQ, one-hot owner; all zero when no owner.
- owner_id, output, 2, index of current or last owner.
- state, output, 2, 0=IDLE, 1=OWN, 2=BLANK.
- switch_pulse, output, 1, one-cycle pulse when a new grant takes effect.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, owner_id=0, switch_pulse=0, all counters 0, fb_q=0.
  - pixel_data=IDLE_COLOUR.
- Frame event: fe = frame_begin & ~fb_q, where fb_q is frame_begin registered. One event per frame_begin rising edge; a held-high frame_begin counts once.
- All state, grant and counter updates happen only on the clock edge where fe=1. switch_pulse is the only exception.
- Round-robin pick: the first i with req[i]=1, searching owner_id+1, owner_id+2, ... modulo NUM_REQ. The search includes owner_id last.
- IDLE:
  - pixel_data=IDLE_COLOUR, grant=0.
  - On fe with req!=0: go to OWN with the picked requester. Set grant and owner_id, hold_cnt=0, switch_pulse=1 for one cycle.
  - No blank frames when leaving IDLE.
- OWN:
  - pixel_data=pix_in[owner] (combinational from registered grant; zero added latency). grant=onehot(owner).
  - On fe, hold_cnt increments, saturating at 255.
  - On fe with req[owner]=0, and another request present: go to BLANK; next owner is the RR pick.
  - On fe with req[owner]=0 and no request: go to IDLE. owner_id is kept.
  - On fe with req[owner]=1, another request present, lock=0 and hold_cnt>=MIN_HOLD_FRAMES (compared before the increment): preempt. Go to BLANK with pending=RR pick, excluding the current owner.
  - Any other case: stay in OWN. lock=1 blocks preemption indefinitely but never a voluntary release.
- BLANK:
  - pixel_data=BLANK_COLOUR, grant=0. blank_cnt counts fe events.
  - On the fe where blank_cnt reaches BLANK_FRAMES: if req[pending]=1, go to OWN(pending) with hold_cnt=0 and switch_pulse=1.
  - Otherwise re-pick from the current req (from pending+1). Go to OWN(pick) if any request exists, else IDLE.
- A requester dropping or raising req between frame events has no effect until the next fe.
- Simultaneous requests from IDLE: the RR pick starts from owner_id+1. After reset that is requester 1 first.
- NUM_REQ=1: preemption never happens.
- Reset asserted mid-frame: immediate return to IDLE outputs. The first grant after release waits for a fresh frame_begin rising edge.
- owner_id width is fixed at 2 bits. Unused grant bits are 0.

Test Plan:
1. Reset, req=3'b001, one frame_begin pulse:
   - Next cycle: grant=001, owner_id=0, state=1, switch_pulse high for exactly 1 cycle.
   - pixel_data equals pix_in[15:0] the same cycle pix_in changes.
2. Owner 0 holding, req=3'b011, lock=0, MIN_HOLD_FRAMES=4:
   - Stays OWN through 4 frame events.
   - On the 5th event: BLANK, with pixel_data=16'h0000 for 2 frames.
   - Then grant=010.
3. Same as 2 with lock=1:
   - grant stays 001 for 20 frames.
   - Drop req[0] → BLANK at the next frame event, then grant=010.
4. Owner 1 drops req, req=3'b000 → IDLE at the next frame event, grant=0, owner_id=1. Then req=3'b101 → next frame event grants 100 (RR from 2).
5. frame_begin held high for 10 cycles while req changes → exactly one frame event; hold_cnt and blank_cnt advance by 1.
6. Pulse reset_n low mid-BLANK:
   - Outputs reset asynchronously (grant=0, state=0) without waiting for a clock.
   - After release, no grant occurs until the next frame_begin rising edge.

Source files
------------

// File: rtl/oled_display_arbiter.sv
// Frame-synchronous arbiter sharing one 96x64 OLED among NUM_REQ pixel producers.
// Round-robin ownership with minimum hold, owner lock and blank frames between owners.
module oled_display_arbiter #(
  parameter int          NUM_REQ         = 3,
  parameter int          MIN_HOLD_FRAMES = 4,
  parameter int          BLANK_FRAMES    = 2,
  parameter logic [15:0] IDLE_COLOUR     = 16'h0000,
  parameter logic [15:0] BLANK_COLOUR    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_begin,
  input  logic [NUM_REQ-1:0]     req,
  input  logic                   lock,
  input  logic [16*NUM_REQ-1:0]  pix_in,
  output logic [15:0]            pixel_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [1:0]             owner_id,
  output logic [1:0]             state,
  output logic                   switch_pulse
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_BLANK = 2'd2} state_e;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_e               state_q;
  logic                 fb_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [1:0]           owner_q, pend_q;
  logic [7:0]           hold_q, blank_q;
  logic                 sw_q;

  logic                 fe;
  logic [NUM_REQ-1:0]   owner_oh, pend_oh;
  logic                 own_req, other_req, any_req, pend_req;
  logic [1:0]           pick_own, pick_pend;
  logic [7:0]           hold_inc, blank_nxt;
  logic [15:0]          pix_mux;

  // First requester after 'base' (wrapping), with 'base' itself checked last.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] base);
    logic [1:0] p;
    logic       found;
    int         idx;
    p     = base;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && ((r & (ONE << idx)) != '0)) begin
        p     = 2'(idx);
        found = 1'b1;
      end
    end
    return p;
  endfunction

  assign fe        = frame_begin & ~fb_q;
  assign owner_oh  = ONE << owner_q;
  assign pend_oh   = ONE << pend_q;
  assign own_req   = |(req & owner_oh);
  assign other_req = |(req & ~owner_oh);
  assign any_req   = |req;
  assign pend_req  = |(req & pend_oh);
  assign pick_own  = rr_pick(req, owner_q);
  assign pick_pend = rr_pick(req, pend_q);
  assign hold_inc  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
  assign blank_nxt = blank_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fb_q    <= 1'b0;
      grant_q <= '0;
      owner_q <= 2'd0;
      pend_q  <= 2'd0;
      hold_q  <= 8'd0;
      blank_q <= 8'd0;
      sw_q    <= 1'b0;
    end else begin
      fb_q <= frame_begin;
      sw_q <= 1'b0;
      if (fe) begin
        case (state_q)
          S_IDLE: begin
            if (any_req) begin
              state_q <= S_OWN;
              owner_q <= pick_own;
              grant_q <= ONE << pick_own;
              hold_q  <= 8'd0;
              sw_q    <= 1'b1;
            end
          end
          S_OWN: begin
            hold_q <= hold_inc;
            if (!own_req) begin
              // Voluntary release is honoured even while locked.
              grant_q <= '0;
              blank_q <= 8'd0;
              if (other_req) begin
                state_q <= S_BLANK;
                pend_q  <= pick_own;
              end else begin
                state_q <= S_IDLE;
              end
            end else if (other_req && !lock && (hold_q >= 8'(MIN_HOLD_FRAMES))) begin
              state_q <= S_BLANK;
              pend_q  <= pick_own;
              grant_q <= '0;
              blank_q <= 8'd0;
            end
          end
          S_BLANK: begin
            blank_q <= blank_nxt;
            if (blank_nxt == 8'(BLANK_FRAMES)) begin
              if (pend_req) begin
                state_q <= S_OWN;
                owner_q <= pend_q;
                grant_q <= pend_oh;
                hold_q  <= 8'd0;
                sw_q    <= 1'b1;
              end else if (any_req) begin
                state_q <= S_OWN;
                owner_q <= pick_pend;
                grant_q <= ONE << pick_pend;
                hold_q  <= 8'd0;
                sw_q    <= 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Pixel path is purely combinational off the registered grant.
  always_comb begin
    pix_mux = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) pix_mux = pix_mux | pix_in[16*i +: 16];
  end

  always_comb begin
    pixel_data = IDLE_COLOUR;
    case (state_q)
      S_OWN:   pixel_data = pix_mux;
      S_BLANK: pixel_data = BLANK_COLOUR;
      default: pixel_data = IDLE_COLOUR;
    endcase
  end

  assign grant        = grant_q;
  assign owner_id     = owner_q;
  assign state        = state_q;
  assign switch_pulse = sw_q;

endmodule

// File: tb/tb_oled_display_arbiter.sv
// Scoreboard bench for oled_display_arbiter: stimulus queues expected state changes
// and grant switches; a negedge monitor pops and compares when the DUT shows them.
module tb_oled_display_arbiter;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            frame_begin;
  logic [NR-1:0]   req;
  logic            lock;
  logic [16*NR-1:0] pix_in;
  logic [15:0]     pixel_data;
  logic [NR-1:0]   grant;
  logic [1:0]      owner_id;
  logic [1:0]      state;
  logic            switch_pulse;

  localparam logic [15:0] P0 = 16'hA000, P1 = 16'h0B11, P2 = 16'h00C2;

  oled_display_arbiter #(.NUM_REQ(NR), .MIN_HOLD_FRAMES(4), .BLANK_FRAMES(2),
                         .IDLE_COLOUR(16'h0000), .BLANK_COLOUR(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin), .req(req), .lock(lock),
    .pix_in(pix_in), .pixel_data(pixel_data), .grant(grant), .owner_id(owner_id),
    .state(state), .switch_pulse(switch_pulse));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [2:0]  gnt;
    logic [1:0]  own;
    logic [15:0] pix;
  } st_exp_t;

  typedef struct {
    string      name;
    logic [2:0] gnt;
    logic [1:0] own;
  } sw_exp_t;

  st_exp_t st_q[$];
  sw_exp_t sw_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic exp_st(input string nm, input logic [1:0] s, input logic [2:0] g,
                        input logic [1:0] o, input logic [15:0] p);
    st_exp_t e;
    e.name = nm; e.st = s; e.gnt = g; e.own = o; e.pix = p;
    st_q.push_back(e);
  endtask

  task automatic exp_sw(input string nm, input logic [2:0] g, input logic [1:0] o);
    sw_exp_t e;
    e.name = nm; e.gnt = g; e.own = o;
    sw_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  // One clean frame_begin pulse, then idle cycles; returns 1 time unit past a posedge.
  task automatic frame();
    @(posedge clk); #1 frame_begin = 1'b1;
    @(posedge clk); #1 frame_begin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // frame_begin held high for 10 cycles; req switches to new_req part way through.
  task automatic frame_long(input logic [NR-1:0] new_req);
    @(posedge clk); #1 frame_begin = 1'b1;
    repeat (4) @(posedge clk);
    #1 req = new_req;
    repeat (6) @(posedge clk);
    #1 frame_begin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: every state change and every switch_pulse cycle consumes one expectation.
  logic [1:0] prev_st = 2'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (state !== prev_st) begin
        n_cmp++;
        if (st_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_state_change: got st=%0d gnt=%b own=%0d", state, grant, owner_id);
        end else begin
          st_exp_t e;
          e = st_q.pop_front();
          if ({state, grant, owner_id, pixel_data} !== {e.st, e.gnt, e.own, e.pix}) begin
            n_bad++;
            $display("FAIL %s: got st=%0d gnt=%b own=%0d pix=%h, expected st=%0d gnt=%b own=%0d pix=%h",
                     e.name, state, grant, owner_id, pixel_data, e.st, e.gnt, e.own, e.pix);
          end
        end
        prev_st = state;
      end
      if (switch_pulse) begin
        n_cmp++;
        if (sw_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_switch_pulse: got gnt=%b own=%0d", grant, owner_id);
        end else begin
          sw_exp_t e;
          e = sw_q.pop_front();
          if ({grant, owner_id} !== {e.gnt, e.own}) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b own=%0d, expected gnt=%b own=%0d",
                     e.name, grant, owner_id, e.gnt, e.own);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; frame_begin = 1'b0; req = '0; lock = 1'b0;
    pix_in = {P2, P1, P0};
    #2;
    chk("reset_state",  32'(state), 32'd0);
    chk("reset_grant",  32'(grant), 32'd0);
    chk("reset_owner",  32'(owner_id), 32'd0);
    chk("reset_switch", 32'(switch_pulse), 32'd0);
    chk("reset_pixel",  32'(pixel_data), 32'h0000);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single requester from IDLE
    req = 3'b001;
    exp_st("t1_own0", 2'd1, 3'b001, 2'd0, P0);
    exp_sw("t1_sw0", 3'b001, 2'd0);
    frame();
    pix_in[15:0] = 16'h1234;
    #1 chk("t1_pix_passthru", 32'(pixel_data), 32'h1234);
    pix_in[15:0] = P0;
    #1 chk("t1_switch_low", 32'(switch_pulse), 32'd0);

    // 2: preemption after minimum hold, two blank frames
    req = 3'b011; lock = 1'b0;
    repeat (4) frame();
    chk("t2_still_own", 32'({state, grant}), 32'({2'd1, 3'b001}));
    exp_st("t2_blank", 2'd2, 3'b000, 2'd0, 16'h0000);
    frame();
    frame();
    exp_st("t2_own1", 2'd1, 3'b010, 2'd1, P1);
    exp_sw("t2_sw1", 3'b010, 2'd1);
    frame();

    // 3/4: lock holds for 20 frames, voluntary release to IDLE, then RR from 2
    lock = 1'b1;
    repeat (20) frame();
    chk("t3_locked_grant", 32'(grant), 32'b010);
    req = 3'b000;
    exp_st("t4_idle", 2'd0, 3'b000, 2'd1, 16'h0000);
    frame();
    req = 3'b101;
    exp_st("t4_own2", 2'd1, 3'b100, 2'd2, P2);
    exp_sw("t4_sw2", 3'b100, 2'd2);
    frame();

    // locked owner releases while others wait: BLANK then RR from 0
    req = 3'b111;
    repeat (6) frame();
    req = 3'b011;
    exp_st("t3_blank", 2'd2, 3'b000, 2'd2, 16'h0000);
    frame();
    frame();
    exp_st("t3_own0", 2'd1, 3'b001, 2'd0, P0);
    exp_sw("t3_sw0", 3'b001, 2'd0);
    frame();

    // 5: held-high frame_begin counts once for hold and blank counters
    lock = 1'b0; req = 3'b001;
    frame_long(3'b011);
    repeat (3) frame();
    exp_st("t5_blank", 2'd2, 3'b000, 2'd0, 16'h0000);
    frame();
    frame_long(3'b111);
    exp_st("t5_own1", 2'd1, 3'b010, 2'd1, P1);
    exp_sw("t5_sw1", 3'b010, 2'd1);
    frame();

    // 6: async reset mid-BLANK, no grant until a fresh frame_begin edge
    req = 3'b011;
    repeat (4) frame();
    exp_st("t6_blank", 2'd2, 3'b000, 2'd1, 16'h0000);
    frame();
    frame();
    exp_st("t6_reset_idle", 2'd0, 3'b000, 2'd0, 16'h0000);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(state), 32'd0);
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_owner", 32'(owner_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("t6_no_grant_wo_edge", 32'({state, grant}), 32'd0);
    exp_st("t6_own1", 2'd1, 3'b010, 2'd1, P1);
    exp_sw("t6_sw1", 3'b010, 2'd1);
    frame();

    repeat (4) @(posedge clk);
    #1;
    chk("state_queue_drained",  32'(st_q.size()), 32'd0);
    chk("switch_queue_drained", 32'(sw_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
